// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// instruction fields and the datapath select codes driven by mc_ctrl.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_RS  = 2'd3;

  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_DM  = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  typedef struct packed {
    logic isAddu;
    logic isSubu;
    logic isOri;
    logic isLui;
    logic isLw;
    logic isSw;
    logic isBeq;
    logic isJal;
    logic isJr;
    logic isNop;
    logic isIllegal;
  } instrClass_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: instruction fields and handshake inputs,
// select/enable outputs and debug status.
interface mc_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       memAck;
  logic       pcWrite;
  logic       irWrite;
  logic [1:0] npcSel;
  logic       regWrite;
  logic [1:0] regDst;
  logic [1:0] memToReg;
  logic       extOp;
  logic       aluSrcB;
  logic [2:0] aluOp;
  logic       memRead;
  logic       memWrite;
  logic [2:0] state;
  logic       illegal;
  logic       busErr;

  modport master (
    input  opcode, funct, zero, memAck,
    output pcWrite, irWrite, npcSel, regWrite, regDst, memToReg, extOp,
           aluSrcB, aluOp, memRead, memWrite, state, illegal, busErr
  );

  modport slave (
    output opcode, funct, zero, memAck,
    input  pcWrite, irWrite, npcSel, regWrite, regDst, memToReg, extOp,
           aluSrcB, aluOp, memRead, memWrite, state, illegal, busErr
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps opcode/funct onto one-hot
// instruction classes; anything outside the supported subset is illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output instrClass_t cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.isAddu    = 1'b1;
          FN_SUBU: cls.isSubu    = 1'b1;
          FN_JR:   cls.isJr      = 1'b1;
          FN_SLL:  cls.isNop     = 1'b1;
          default: cls.isIllegal = 1'b1;
        endcase
      end
      OP_ORI:  cls.isOri     = 1'b1;
      OP_LUI:  cls.isLui     = 1'b1;
      OP_LW:   cls.isLw      = 1'b1;
      OP_SW:   cls.isSw      = 1'b1;
      OP_BEQ:  cls.isBeq     = 1'b1;
      OP_JAL:  cls.isJal     = 1'b1;
      default: cls.isIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// bounded data-memory wait; all selects are decoded from state and IR fields.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  mc_if.master bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      curState;
  state_t      nextState;
  logic [7:0]  waitCnt;
  logic        memTimeout;
  instrClass_t cls;

  mc_decode uDecode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls)
  );

  // waitCnt counts MEM cycles already spent; the last allowed cycle times out
  // unless memAck arrives in that same cycle.
  assign memTimeout = (waitCnt == WAIT_LAST) && !bus.memAck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState <= S_FETCH;
      waitCnt  <= '0;
    end else begin
      curState <= nextState;
      if (curState == S_MEM && nextState == S_MEM) waitCnt <= waitCnt + 8'd1;
      else                                         waitCnt <= '0;
    end
  end

  always_comb begin
    nextState = S_FETCH;
    case (curState)
      S_FETCH:  nextState = S_DECODE;
      S_DECODE: begin
        if (cls.isJal || cls.isJr || cls.isNop || cls.isIllegal) nextState = S_FETCH;
        else                                                     nextState = S_EXEC;
      end
      S_EXEC: begin
        if (cls.isLw || cls.isSw) nextState = S_MEM;
        else if (cls.isBeq)       nextState = S_FETCH;
        else                      nextState = S_WB;
      end
      S_MEM: begin
        if (bus.memAck)      nextState = cls.isLw ? S_WB : S_FETCH;
        else if (memTimeout) nextState = S_FETCH;
        else                 nextState = S_MEM;
      end
      S_WB:    nextState = S_FETCH;
      default: nextState = S_FETCH;
    endcase
  end

  assign bus.state = curState;

  // Enables are held low while reset is asserted so nothing fires before release.
  always_comb begin
    bus.pcWrite  = 1'b0;
    bus.irWrite  = 1'b0;
    bus.npcSel   = NPC_PC4;
    bus.regWrite = 1'b0;
    bus.regDst   = RDST_RT;
    bus.memToReg = M2R_ALU;
    bus.extOp    = 1'b0;
    bus.aluSrcB  = 1'b0;
    bus.aluOp    = ALU_ADD;
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    bus.illegal  = 1'b0;
    bus.busErr   = 1'b0;
    if (rst_n) begin
      // ALU controls persist from EXEC through MEM/WB so address/result stay stable.
      if (curState inside {S_EXEC, S_MEM, S_WB}) begin
        if (cls.isSubu || cls.isBeq) bus.aluOp = ALU_SUB;
        else if (cls.isOri)          bus.aluOp = ALU_OR;
        else if (cls.isLui)          bus.aluOp = ALU_LUI;
        else                         bus.aluOp = ALU_ADD;
        bus.extOp   = cls.isLw || cls.isSw || cls.isBeq;
        bus.aluSrcB = cls.isOri || cls.isLui || cls.isLw || cls.isSw;
      end
      case (curState)
        S_FETCH: begin
          bus.irWrite = 1'b1;
          bus.pcWrite = 1'b1;
          bus.npcSel  = NPC_PC4;
        end
        S_DECODE: begin
          bus.illegal = cls.isIllegal;
          if (cls.isJal) begin
            bus.regWrite = 1'b1;
            bus.regDst   = RDST_RA;
            bus.memToReg = M2R_PC4;
            bus.pcWrite  = 1'b1;
            bus.npcSel   = NPC_J;
          end else if (cls.isJr) begin
            bus.pcWrite = 1'b1;
            bus.npcSel  = NPC_RS;
          end
        end
        S_EXEC: begin
          if (cls.isBeq) begin
            bus.pcWrite = bus.zero;
            bus.npcSel  = NPC_BR;
          end
        end
        S_MEM: begin
          bus.memRead  = cls.isLw;
          bus.memWrite = cls.isSw;
          bus.busErr   = memTimeout;
        end
        S_WB: begin
          bus.regWrite = 1'b1;
          bus.regDst   = (cls.isAddu || cls.isSubu) ? RDST_RD : RDST_RT;
          bus.memToReg = cls.isLw ? M2R_DM : M2R_ALU;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-cycle vector table for the short instruction flows,
// plus directed sequences for reset, MEM timeout and late acknowledge.
module tb_mc_ctrl;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mc_if bus ();

  mc_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcW;
    logic       irW;
    logic [1:0] npc;
    logic       rW;
    logic [1:0] rDst;
    logic [1:0] m2r;
    logic       ext;
    logic       srcB;
    logic [2:0] alu;
    logic       mR;
    logic       mW;
    logic       ill;
    logic       be;
  } outs_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       ack;
    outs_t      exp;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nErrors = 0;

  function automatic outs_t mk(input logic [2:0] st, input logic pcW, input logic irW,
                               input logic [1:0] npc, input logic rW, input logic [1:0] rDst,
                               input logic [1:0] m2r, input logic ext, input logic srcB,
                               input logic [2:0] alu, input logic mR, input logic mW,
                               input logic ill, input logic be);
    outs_t o;
    o.st = st; o.pcW = pcW; o.irW = irW; o.npc = npc; o.rW = rW; o.rDst = rDst;
    o.m2r = m2r; o.ext = ext; o.srcB = srcB; o.alu = alu; o.mR = mR; o.mW = mW;
    o.ill = ill; o.be = be;
    return o;
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a.st = bus.state; a.pcW = bus.pcWrite; a.irW = bus.irWrite; a.npc = bus.npcSel;
    a.rW = bus.regWrite; a.rDst = bus.regDst; a.m2r = bus.memToReg; a.ext = bus.extOp;
    a.srcB = bus.aluSrcB; a.alu = bus.aluOp; a.mR = bus.memRead; a.mW = bus.memWrite;
    a.ill = bus.illegal; a.be = bus.busErr;
    return a;
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic ack, input outs_t e);
    vec_t v;
    v.op = op; v.fn = fn; v.zero = z; v.ack = ack; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic ack);
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    bus.memAck = ack;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Advance (bounded) until the controller sits in FETCH; sample point is negedge+1.
  task automatic syncFetch(input string tag);
    for (int i = 0; i < 8 && bus.state != S_FETCH; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, " sync fetch"}, 32'(bus.state), 32'(S_FETCH));
  endtask

  // Full lw/sw flow holding MEM for 16 cycles; ack only in the 16th if ackAtLast.
  task automatic memLong(input string tag, input logic [5:0] op, input bit ackAtLast);
    int reqCycles = 0;
    int errPulses = 0;
    int errAt = -1;
    int regW = 0;
    syncFetch(tag);
    drive(op, 6'h00, 1'b0, 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check({tag, " exec"}, 32'(bus.state), 32'(S_EXEC));
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.memAck = ackAtLast && (k == 15);
      #1;
      if (bus.state == S_MEM && (bus.memRead || bus.memWrite)) reqCycles++;
      if (bus.busErr) begin
        errPulses++;
        errAt = k;
      end
      if (bus.regWrite) regW++;
    end
    @(negedge clk);
    bus.memAck = 1'b0;
    #1;
    check({tag, " req cycles"}, 32'(reqCycles), 32'd16);
    if (ackAtLast) begin
      check({tag, " no busErr"}, 32'(errPulses), 32'd0);
      check({tag, " to WB"}, 32'(bus.state), 32'(S_WB));
      check({tag, " WB memToReg"}, 32'(bus.memToReg), 32'(M2R_DM));
      check({tag, " WB regWrite"}, 32'(bus.regWrite), 32'd1);
    end else begin
      check({tag, " busErr pulses"}, 32'(errPulses), 32'd1);
      check({tag, " busErr cycle"}, 32'(errAt), 32'd15);
      check({tag, " back to FETCH"}, 32'(bus.state), 32'(S_FETCH));
      check({tag, " req dropped"}, 32'(bus.memRead | bus.memWrite), 32'd0);
      check({tag, " no regWrite"}, 32'(regW + int'(bus.regWrite)), 32'd0);
    end
  endtask

  outs_t rF, rD, rLsE, rLwM, rSwM;

  initial begin
    rF   = mk(3'd0, 1, 1, NPC_PC4, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0);
    rD   = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0);
    rLsE = mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 1, ALU_ADD, 0, 0, 0, 0);
    rLwM = mk(3'd3, 0, 0, 0, 0, 0, 0, 1, 1, ALU_ADD, 1, 0, 0, 0);
    rSwM = mk(3'd3, 0, 0, 0, 0, 0, 0, 1, 1, ALU_ADD, 0, 1, 0, 0);

    // addu
    add(6'h00, 6'h21, 0, 0, rF);
    add(6'h00, 6'h21, 0, 0, rD);
    add(6'h00, 6'h21, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0));
    add(6'h00, 6'h21, 0, 0, mk(3'd4, 0, 0, 0, 1, RDST_RD, M2R_ALU, 0, 0, ALU_ADD, 0, 0, 0, 0));
    // subu
    add(6'h00, 6'h23, 0, 0, rF);
    add(6'h00, 6'h23, 0, 0, rD);
    add(6'h00, 6'h23, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, ALU_SUB, 0, 0, 0, 0));
    add(6'h00, 6'h23, 0, 0, mk(3'd4, 0, 0, 0, 1, RDST_RD, M2R_ALU, 0, 0, ALU_SUB, 0, 0, 0, 0));
    // ori (funct field is immediate bits)
    add(6'h0D, 6'h15, 0, 0, rF);
    add(6'h0D, 6'h15, 0, 0, rD);
    add(6'h0D, 6'h15, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, ALU_OR, 0, 0, 0, 0));
    add(6'h0D, 6'h15, 0, 0, mk(3'd4, 0, 0, 0, 1, RDST_RT, M2R_ALU, 0, 1, ALU_OR, 0, 0, 0, 0));
    // lui
    add(6'h0F, 6'h08, 0, 0, rF);
    add(6'h0F, 6'h08, 0, 0, rD);
    add(6'h0F, 6'h08, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, ALU_LUI, 0, 0, 0, 0));
    add(6'h0F, 6'h08, 0, 0, mk(3'd4, 0, 0, 0, 1, RDST_RT, M2R_ALU, 0, 1, ALU_LUI, 0, 0, 0, 0));
    // beq taken / not taken
    add(6'h04, 6'h00, 1, 0, rF);
    add(6'h04, 6'h00, 1, 0, rD);
    add(6'h04, 6'h00, 1, 0, mk(3'd2, 1, 0, NPC_BR, 0, 0, 0, 1, 0, ALU_SUB, 0, 0, 0, 0));
    add(6'h04, 6'h00, 0, 0, rF);
    add(6'h04, 6'h00, 0, 0, rD);
    add(6'h04, 6'h00, 0, 0, mk(3'd2, 0, 0, NPC_BR, 0, 0, 0, 1, 0, ALU_SUB, 0, 0, 0, 0));
    // jal, jr, nop
    add(6'h03, 6'h00, 0, 0, rF);
    add(6'h03, 6'h00, 0, 0, mk(3'd1, 1, 0, NPC_J, 1, RDST_RA, M2R_PC4, 0, 0, ALU_ADD, 0, 0, 0, 0));
    add(6'h00, 6'h08, 0, 0, rF);
    add(6'h00, 6'h08, 0, 0, mk(3'd1, 1, 0, NPC_RS, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0));
    add(6'h00, 6'h00, 0, 0, rF);
    add(6'h00, 6'h00, 0, 0, rD);
    // illegal opcode and illegal R-type funct
    add(6'h3F, 6'h00, 0, 0, rF);
    add(6'h3F, 6'h00, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 0));
    add(6'h00, 6'h2A, 0, 0, rF);
    add(6'h00, 6'h2A, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 0));
    // lw with ack in third MEM cycle
    add(6'h23, 6'h00, 0, 0, rF);
    add(6'h23, 6'h00, 0, 0, rD);
    add(6'h23, 6'h00, 0, 0, rLsE);
    add(6'h23, 6'h00, 0, 0, rLwM);
    add(6'h23, 6'h00, 0, 0, rLwM);
    add(6'h23, 6'h00, 0, 1, rLwM);
    add(6'h23, 6'h00, 0, 0, mk(3'd4, 0, 0, 0, 1, RDST_RT, M2R_DM, 1, 1, ALU_ADD, 0, 0, 0, 0));
    add(6'h23, 6'h00, 0, 0, rF);
    // sw with immediate ack
    add(6'h2B, 6'h00, 0, 0, rD);
    add(6'h2B, 6'h00, 0, 0, rLsE);
    add(6'h2B, 6'h00, 0, 1, rSwM);

    drive(6'h00, 6'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("reset state", 32'(bus.state), 32'(S_FETCH));
    check("reset enables", 32'({bus.irWrite, bus.pcWrite, bus.regWrite, bus.memRead, bus.memWrite}), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].op, vecs[i].fn, vecs[i].zero, vecs[i].ack);
      #1;
      nChecks++;
      if (actual() !== vecs[i].exp) begin
        nErrors++;
        $display("FAIL vec[%0d] op=%h fn=%h: got %h expected %h",
                 i, vecs[i].op, vecs[i].fn, actual(), vecs[i].exp);
      end
    end

    // Asynchronous reset in the middle of EXEC
    syncFetch("rstExec");
    drive(6'h00, 6'h21, 1'b0, 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("rstExec in exec", 32'(bus.state), 32'(S_EXEC));
    #2 rst_n = 1'b0;
    #1;
    check("rstExec state", 32'(bus.state), 32'(S_FETCH));
    check("rstExec irWrite held", 32'(bus.irWrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstExec release fetch", 32'({bus.irWrite, bus.pcWrite}), 32'b11);

    memLong("swTimeout", OP_SW, 1'b0);
    memLong("lwAckLast", OP_LW, 1'b1);

    // Asynchronous reset after 10 MEM cycles; the next timeout must still take 16
    syncFetch("rstMem");
    drive(OP_LW, 6'h00, 1'b0, 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    repeat (10) @(negedge clk);
    #1;
    check("rstMem memRead", 32'(bus.memRead), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstMem req drop", 32'(bus.memRead), 32'd0);
    check("rstMem state", 32'(bus.state), 32'(S_FETCH));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    memLong("swAfterRst", OP_SW, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
